frame_mem_arbiter: RTL and testbench

//  Shares the single-port grayscale frame RAM between the VGA display fetch and one processing client.

---
 rtl/frame_mem_arbiter_if.sv | 45 ++++
 rtl/frame_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_frame_mem_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/frame_mem_arbiter_if.sv
// ============================================================================
// Module  : frame_mem_arbiter_if
// Brief   : Display, client and frame-RAM signal bundle for frame_mem_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface frame_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              frame_start;
    logic              disp_active;
    logic              disp_valid;
    logic [DATA_W-1:0] disp_data;
    logic              cli_req;
    logic              cli_we;
    logic [ADDR_W-1:0] cli_addr;
    logic [DATA_W-1:0] cli_wdata;
    logic              cli_gnt;
    logic              cli_rvalid;
    logic [DATA_W-1:0] cli_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              frame_done;
    logic              underrun;

    // Arbiter side
    modport slave (
        input  frame_start, disp_active, cli_req, cli_we, cli_addr, cli_wdata, mem_rdata,
        output disp_valid, disp_data, cli_gnt, cli_rvalid, cli_rdata,
        output mem_addr, mem_we, mem_wdata, frame_done, underrun
    );

    // Timing generator / client / RAM side
    modport master (
        output frame_start, disp_active, cli_req, cli_we, cli_addr, cli_wdata, mem_rdata,
        input  disp_valid, disp_data, cli_gnt, cli_rvalid, cli_rdata,
        input  mem_addr, mem_we, mem_wdata, frame_done, underrun
    );
endinterface

`default_nettype wire

// File: rtl/frame_mem_arbiter.sv
// ============================================================================
// Module  : frame_mem_arbiter
// Brief   : Shares a single-port frame RAM between VGA display fetch (priority)
//           and one client. Optional macro TEAR_GUARD_EN restricts client
//           writes to IDLE/VBLANK.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256
) (
    input  wire logic             clk,
    input  wire logic             rst,
    frame_mem_arbiter_if.slave    bus
);

    localparam logic [ADDR_W-1:0] c_LAST_PIX = ADDR_W'(IMG_W * IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_VBLANK = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pix_cnt;
    logic              r_disp_valid;
    logic              r_cli_rvalid;
    logic [DATA_W-1:0] r_cli_rdata;
    logic              r_frame_done;
    logic              r_underrun;

    logic              w_disp_issue;
    logic              w_last;
    logic              w_wr_ok;
    logic              w_gnt;
    logic [ADDR_W-1:0] w_mem_addr;
    logic              w_mem_we;
    logic [DATA_W-1:0] w_mem_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_disp_issue = 1'b0;
        w_last       = 1'b0;
        w_wr_ok      = 1'b0;
        w_gnt        = 1'b0;
        w_mem_addr   = '0;
        w_mem_we     = 1'b0;
        w_mem_wdata  = '0;

        w_disp_issue = (r_state == S_ACTIVE) && bus.disp_active && !bus.frame_start;
        w_last       = (r_pix_cnt == c_LAST_PIX);

`ifdef TEAR_GUARD_EN
        w_wr_ok = (r_state != S_ACTIVE);
`else
        w_wr_ok = 1'b1;
`endif

        // Gating with rst keeps the RAM port quiet while reset is asserted.
        w_gnt = rst && bus.cli_req && !w_disp_issue && (!bus.cli_we || w_wr_ok);

        if (w_disp_issue) begin
            w_mem_addr = r_pix_cnt;
        end else if (w_gnt) begin
            w_mem_addr = bus.cli_addr;
            w_mem_we   = bus.cli_we;
            if (bus.cli_we) begin
                w_mem_wdata = bus.cli_wdata;
            end
        end

        if (bus.frame_start) begin
            w_state_nxt = S_ACTIVE;
        end else if (w_disp_issue && w_last) begin
            w_state_nxt = S_VBLANK;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pix_cnt    <= '0;
            r_disp_valid <= 1'b0;
            r_cli_rvalid <= 1'b0;
            r_cli_rdata  <= '0;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_disp_valid <= w_disp_issue;
            r_cli_rvalid <= w_gnt && !bus.cli_we;
            r_frame_done <= w_disp_issue && w_last;
            if (r_cli_rvalid) begin
                r_cli_rdata <= bus.mem_rdata;
            end
            if (bus.frame_start && (r_state == S_ACTIVE)) begin
                r_underrun <= 1'b1;
            end
            // The counter parks on the last pixel; only frame_start rewinds it.
            if (bus.frame_start) begin
                r_pix_cnt <= '0;
            end else if (w_disp_issue && !w_last) begin
                r_pix_cnt <= r_pix_cnt + ADDR_W'(1);
            end
        end
    end

    // RAM data arrives one cycle after the address, in the same cycle as the valid flags.
    assign bus.disp_valid = r_disp_valid;
    assign bus.disp_data  = r_disp_valid ? bus.mem_rdata : '0;
    assign bus.cli_gnt    = w_gnt;
    assign bus.cli_rvalid = r_cli_rvalid;
    assign bus.cli_rdata  = r_cli_rvalid ? bus.mem_rdata : r_cli_rdata;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_we     = w_mem_we;
    assign bus.mem_wdata  = w_mem_wdata;
    assign bus.frame_done = r_frame_done;
    assign bus.underrun   = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_frame_mem_arbiter.sv
// ============================================================================
// Module  : tb_frame_mem_arbiter
// Brief   : Directed bench for frame_mem_arbiter with a behavioural frame RAM
//           and scoreboards for display and client read data.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_mem_arbiter;

    localparam int c_ADDR_W = 16;
    localparam int c_DATA_W = 8;
    localparam int c_IMG_W  = 4;
    localparam int c_IMG_H  = 2;
    localparam int c_NPIX   = c_IMG_W * c_IMG_H;

    logic clk;
    logic rst;

    frame_mem_arbiter_if #(.ADDR_W(c_ADDR_W), .DATA_W(c_DATA_W)) bus ();

    frame_mem_arbiter #(
        .ADDR_W(c_ADDR_W), .DATA_W(c_DATA_W), .IMG_W(c_IMG_W), .IMG_H(c_IMG_H)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] ram     [0:255];
    logic [7:0] exp_mem [0:255];
    logic [7:0] sb_disp [$];
    logic [7:0] sb_cli  [$];
    int         n_total = 0;
    int         n_pass  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Scoreboard monitors, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.disp_valid === 1'b1) begin
            if (sb_disp.size() == 0) chk("disp_extra", {31'b0, bus.disp_valid}, 32'd0);
            else chk("disp_data", {24'b0, bus.disp_data}, {24'b0, sb_disp.pop_front()});
        end
        if (bus.cli_rvalid === 1'b1) begin
            if (sb_cli.size() == 0) chk("cli_extra", {31'b0, bus.cli_rvalid}, 32'd0);
            else chk("cli_rdata", {24'b0, bus.cli_rdata}, {24'b0, sb_cli.pop_front()});
        end
    end

    task automatic step(input logic fs, input logic da, input logic rq, input logic we,
                        input logic [15:0] a, input logic [7:0] wd);
        @(posedge clk);
        #1;
        bus.frame_start = fs;
        bus.disp_active = da;
        bus.cli_req     = rq;
        bus.cli_we      = we;
        bus.cli_addr    = a;
        bus.cli_wdata   = wd;
        #1;
    endtask

    task automatic issue_px(input int k, input logic rq, input logic we,
                            input logic [15:0] a, input logic [7:0] wd);
        step(1'b0, 1'b1, rq, we, a, wd);
        chk("disp_addr", {16'b0, bus.mem_addr}, k);
        chk("disp_we", {31'b0, bus.mem_we}, 32'd0);
        sb_disp.push_back(exp_mem[k]);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 8'(i);
            exp_mem[i] = 8'(i);
        end
        rst             = 1'b0;
        bus.frame_start = 1'b0;
        bus.disp_active = 1'b0;
        bus.cli_req     = 1'b0;
        bus.cli_we      = 1'b0;
        bus.cli_addr    = '0;
        bus.cli_wdata   = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_disp_valid", {31'b0, bus.disp_valid}, 0);
        chk("rst_disp_data", {24'b0, bus.disp_data}, 0);
        chk("rst_cli_rvalid", {31'b0, bus.cli_rvalid}, 0);
        chk("rst_cli_rdata", {24'b0, bus.cli_rdata}, 0);
        chk("rst_frame_done", {31'b0, bus.frame_done}, 0);
        chk("rst_underrun", {31'b0, bus.underrun}, 0);
        rst = 1'b1;

        // 1: full frame fetch
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        chk("fs_no_issue_we", {31'b0, bus.mem_we}, 0);
        chk("fs_no_issue_addr", {16'b0, bus.mem_addr}, 0);
        for (int k = 0; k < c_NPIX; k++) issue_px(k, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        chk("frame_done_pulse", {31'b0, bus.frame_done}, 1);
        chk("vblank_no_issue", {16'b0, bus.mem_addr}, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        chk("frame_done_single", {31'b0, bus.frame_done}, 0);
        chk("vblank_disp_valid", {31'b0, bus.disp_valid}, 0);

        // 2: client read blocked by display, granted in a free slot
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 6, 0);
        chk("rd_blocked_gnt", {31'b0, bus.cli_gnt}, 0);
        chk("rd_blocked_addr", {16'b0, bus.mem_addr}, 0);
        sb_disp.push_back(exp_mem[0]);
        step(1'b0, 1'b0, 1'b1, 1'b0, 6, 0);
        chk("rd_gnt", {31'b0, bus.cli_gnt}, 1);
        chk("rd_addr", {16'b0, bus.mem_addr}, 6);
        chk("rd_we", {31'b0, bus.mem_we}, 0);
        sb_cli.push_back(exp_mem[6]);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("rd_rvalid", {31'b0, bus.cli_rvalid}, 1);
        chk("idle_addr", {16'b0, bus.mem_addr}, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("rd_rvalid_drop", {31'b0, bus.cli_rvalid}, 0);
        chk("rd_rdata_hold", {24'b0, bus.cli_rdata}, 6);

        // 3: client write in a free ACTIVE slot
        step(1'b0, 1'b0, 1'b1, 1'b1, 3, 8'hAA);
`ifdef TEAR_GUARD_EN
        chk("wr_guard_gnt", {31'b0, bus.cli_gnt}, 0);
        for (int k = 1; k < c_NPIX; k++) issue_px(k, 1'b1, 1'b1, 3, 8'hAA);
        step(1'b0, 1'b0, 1'b1, 1'b1, 3, 8'hAA);
        chk("wr_vblank_gnt", {31'b0, bus.cli_gnt}, 1);
        chk("wr_we", {31'b0, bus.mem_we}, 1);
        chk("wr_addr", {16'b0, bus.mem_addr}, 3);
        chk("wr_wdata", {24'b0, bus.mem_wdata}, 32'hAA);
        exp_mem[3] = 8'hAA;
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
`else
        chk("wr_gnt", {31'b0, bus.cli_gnt}, 1);
        chk("wr_we", {31'b0, bus.mem_we}, 1);
        chk("wr_addr", {16'b0, bus.mem_addr}, 3);
        chk("wr_wdata", {24'b0, bus.mem_wdata}, 32'hAA);
        exp_mem[3] = 8'hAA;
        for (int k = 1; k < c_NPIX; k++) issue_px(k, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
`endif
        chk("wr_no_rvalid", {31'b0, bus.cli_rvalid}, 0);

        // 4: new frame reads back 0xAA, then restart after 5 pixels
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        for (int k = 0; k < 5; k++) issue_px(k, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        chk("restart_no_issue_addr", {16'b0, bus.mem_addr}, 0);
        issue_px(0, 1'b0, 1'b0, 0, 0);
        chk("underrun_set", {31'b0, bus.underrun}, 1);
        chk("restart_no_done", {31'b0, bus.frame_done}, 0);
        for (int k = 1; k < c_NPIX; k++) issue_px(k, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("restart_frame_done", {31'b0, bus.frame_done}, 1);
        chk("underrun_sticky", {31'b0, bus.underrun}, 1);

        // 5: reset during a client read grant
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 5, 0);
        chk("rst_case_gnt", {31'b0, bus.cli_gnt}, 1);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("rst_mid_rvalid", {31'b0, bus.cli_rvalid}, 0);
        chk("rst_mid_rdata", {24'b0, bus.cli_rdata}, 0);
        chk("rst_mid_underrun", {31'b0, bus.underrun}, 0);
        chk("rst_mid_disp_data", {24'b0, bus.disp_data}, 0);
        chk("rst_mid_we", {31'b0, bus.mem_we}, 0);
        rst = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        chk("post_rst_disp_valid", {31'b0, bus.disp_valid}, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        issue_px(0, 1'b0, 1'b0, 0, 0);
        issue_px(1, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

        chk("sb_disp_empty", sb_disp.size(), 0);
        chk("sb_cli_empty", sb_cli.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
